// File: rtl/pbs_move_entry.sv
// pbs_move_entry
//   Player input front end. Synchronises and debounces two active-low
//   pushbuttons (confirm, cancel), then hands one latched move per confirm
//   press to the control FSM over a valid/ack handshake.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   key_n[1:0]   raw buttons, active low: [0] confirm, [1] cancel
//   move_sel     move index from switches, sampled on a confirm press
//   enable       FSM is waiting for a player move
//   move_ack     FSM consumed the move (honoured only in HOLD)
//   move_valid   latched move available
//   move         latched move index, stable while move_valid=1
//   press_count  accepted moves since reset, saturating at 15
//   state_led    one-hot state: [0] IDLE, [1] HOLD, [2] WAIT_REL

// One button: two-flop synchroniser followed by a stability-count debouncer.
module pbs_key_debounce #(
    parameter int DB_W            = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic level
);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync   <= 2'b11;
            level  <= 1'b1;
            db_cnt <= '0;
        end else begin
            sync <= {sync[0], key_n};
            if (sync[1] == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                // This sample would be the DEBOUNCE_CYCLES-th differing one.
                level  <= sync[1];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end
endmodule

module pbs_move_entry #(
    parameter int DB_W            = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] key_n,
    input  logic [1:0] move_sel,
    input  logic       enable,
    input  logic       move_ack,
    output logic       move_valid,
    output logic [1:0] move,
    output logic [3:0] press_count,
    output logic [2:0] state_led
);
    localparam int NUM_KEYS = 2;

    // Encoding is the lamp pattern itself, so state_led is a plain register.
    typedef enum logic [2:0] {
        IDLE     = 3'b001,
        HOLD     = 3'b010,
        WAIT_REL = 3'b100
    } state_t;

    logic [NUM_KEYS-1:0] db_level;
    logic [NUM_KEYS-1:0] db_prev;
    logic [NUM_KEYS-1:0] press;
    state_t              state;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        pbs_key_debounce #(
            .DB_W           (DB_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .key_n  (key_n[k]),
            .level  (db_level[k])
        );
    end

    // Press = debounced 1->0 transition; high for exactly one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) db_prev <= '1;
        else          db_prev <= db_level;
    end
    assign press = db_prev & ~db_level;

    assign state_led = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            move_valid  <= 1'b0;
            move        <= 2'b00;
            press_count <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Presses while disabled are dropped; a key already held
                    // when enable rises has no pending edge, so it cannot fire.
                    if (press[0] && enable) begin
                        move       <= move_sel;
                        move_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (move_ack) begin
                        move_valid <= 1'b0;
                        if (press_count != 4'd15) press_count <= press_count + 4'd1;
                        state      <= WAIT_REL;
                    end else if (press[1] || !enable) begin
                        move_valid <= 1'b0;
                        state      <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (db_level[0]) state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    move_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pbs_move_entry.sv
module tb_pbs_move_entry;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] key_n;
    logic [1:0] move_sel;
    logic       enable;
    logic       move_ack;
    logic       move_valid;
    logic [1:0] move;
    logic [3:0] press_count;
    logic [2:0] state_led;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    logic [1:0] exp_q[$];
    logic       prev_valid = 1'b0;

    pbs_move_entry #(.DB_W(16), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_n      (key_n),
        .move_sel   (move_sel),
        .enable     (enable),
        .move_ack   (move_ack),
        .move_valid (move_valid),
        .move       (move),
        .press_count(press_count),
        .state_led  (state_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: each rising move_valid pops the move expected for it.
    always @(negedge clk) begin
        if (move_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 8'(move_valid), 8'd0);
            end else begin
                check("sb_move", 8'(move), 8'(exp_q.pop_front()));
            end
        end
        prev_valid = move_valid;
    end

    task automatic wait_valid(input string tag);
        int i;
        for (i = 0; i < 30; i++) begin
            if (move_valid) break;
            tick(1);
        end
        check(tag, 8'(move_valid), 8'd1);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 30; i++) begin
            if (state_led == 3'b001) break;
            tick(1);
        end
        check(tag, 8'(state_led), 8'h1);
    endtask

    task automatic press_confirm(input logic [1:0] sel);
        move_sel = sel;
        exp_q.push_back(sel);
        key_n[0] = 1'b0;
    endtask

    task automatic release_all();
        key_n = 2'b11;
        wait_idle("release_idle");
    endtask

    task automatic do_ack();
        move_ack = 1'b1;
        tick(1);
        move_ack = 1'b0;
        if (exp_cnt < 15) exp_cnt++;
    endtask

    initial begin
        reset_n = 1'b0; key_n = 2'b11; move_sel = 2'b00; enable = 1'b0; move_ack = 1'b0;
        tick(2);
        check("rst_valid", 8'(move_valid), 8'd0);
        check("rst_move",  8'(move),       8'd0);
        check("rst_count", 8'(press_count), 8'd0);
        check("rst_state", 8'(state_led),  8'h1);
        reset_n = 1'b1;
        tick(2);

        // Basic press: latency, move latching, ack, release latency.
        enable = 1'b1;
        press_confirm(2'b10);
        tick(6);
        check("lat_pre_valid", 8'(move_valid), 8'd0);
        tick(1);
        check("lat_valid", 8'(move_valid), 8'd1);
        check("lat_move",  8'(move),       8'h2);
        check("hold_state", 8'(state_led), 8'h2);
        move_sel = 2'b01;
        tick(3);
        check("hold_move_stable", 8'(move), 8'h2);
        do_ack();
        check("ack_valid", 8'(move_valid), 8'd0);
        check("ack_count", 8'(press_count), 8'(exp_cnt));
        check("ack_state", 8'(state_led),  8'h4);
        key_n[0] = 1'b1;
        tick(6);
        check("rel_pre_idle", 8'(state_led), 8'h4);
        tick(1);
        check("rel_idle", 8'(state_led), 8'h1);

        // Bounce shorter than the debounce window never registers.
        for (int r = 0; r < 5; r++) begin
            key_n[0] = 1'b0; tick(3);
            key_n[0] = 1'b1; tick(1);
        end
        tick(10);
        check("bounce_state", 8'(state_led),  8'h1);
        check("bounce_valid", 8'(move_valid), 8'd0);

        // Held while disabled, then enabled: no move until a fresh press.
        enable = 1'b0;
        key_n[0] = 1'b0;
        tick(10);
        enable = 1'b1;
        tick(6);
        check("held_en_valid", 8'(move_valid), 8'd0);
        check("held_en_state", 8'(state_led),  8'h1);
        key_n[0] = 1'b1;
        tick(10);
        press_confirm(2'b11);
        wait_valid("repress_valid");
        do_ack();
        check("repress_count", 8'(press_count), 8'(exp_cnt));
        release_all();

        // Ack and cancel in the same cycle: ack wins.
        press_confirm(2'b01);
        wait_valid("ackcan_valid");
        key_n[1] = 1'b0;
        tick(6);
        do_ack();
        check("ackcan_valid_lo", 8'(move_valid), 8'd0);
        check("ackcan_count", 8'(press_count), 8'(exp_cnt));
        release_all();

        // Cancel only.
        press_confirm(2'b10);
        wait_valid("can_valid");
        key_n[1] = 1'b0;
        tick(6);
        check("can_pre", 8'(move_valid), 8'd1);
        tick(1);
        check("can_valid_lo", 8'(move_valid), 8'd0);
        check("can_count", 8'(press_count), 8'(exp_cnt));
        check("can_state", 8'(state_led), 8'h4);
        release_all();

        // Enable dropped in HOLD.
        press_confirm(2'b00);
        wait_valid("endrop_valid");
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        check("endrop_valid_lo", 8'(move_valid), 8'd0);
        check("endrop_count", 8'(press_count), 8'(exp_cnt));
        release_all();

        // Cancel outside HOLD does nothing.
        key_n[1] = 1'b0;
        tick(10);
        check("can_idle_state", 8'(state_led), 8'h1);
        key_n[1] = 1'b1;
        tick(8);

        // Saturation over 17 accepted moves.
        for (int p = 0; p < 17; p++) begin
            press_confirm(2'(p));
            wait_valid("sat_valid");
            do_ack();
            check("sat_count", 8'(press_count), 8'(exp_cnt));
            release_all();
        end
        check("sat_final", 8'(press_count), 8'd15);

        // Asynchronous reset mid-HOLD.
        press_confirm(2'b11);
        wait_valid("arst_valid");
        #3 reset_n = 1'b0;
        #1;
        check("arst_valid_lo", 8'(move_valid), 8'd0);
        check("arst_count",    8'(press_count), 8'd0);
        check("arst_state",    8'(state_led),  8'h1);
        key_n = 2'b11;
        tick(2);
        reset_n = 1'b1;
        exp_cnt = 0;
        tick(20);
        check("arst_no_move", 8'(move_valid), 8'd0);
        press_confirm(2'b01);
        wait_valid("arst_new_valid");
        do_ack();
        check("arst_new_count", 8'(press_count), 8'(exp_cnt));
        release_all();
        check("sb_empty", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
